neopixel_rx: RTL

- Single-wire WS2812 (NeoPixel) stream receiver: the receive end of the protocol the NeoPixel transmit driver generates.
- Measures each high pulse to classify the bit, assembles bytes MSB-first and writes them into an external frame buffer through a write port.
- Used for loopback self-test of the LED output chain and for capturing frames from an external controller into the same LEDS*3-byte buffer layout (G,R,B per LED).

---
 rtl/neopixel_pkg.sv | 38 +++
 rtl/neopixel_sync2.sv | 50 +++++
 rtl/neopixel_rx.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/neopixel_pkg.sv
// -----------------------------------------------------------------------------
// neopixel_pkg
//
// Shared definitions for the NeoPixel (WS2812) transmit driver and receiver.
//   - Protocol timing constants in nanoseconds / microseconds.
//   - ns_to_tck / us_to_tck : convert a duration into i_clk ticks using
//     integer division (clk_hz / 1_000_000 * duration / 1000).
//   - rx_state_t : receiver state encoding.
// -----------------------------------------------------------------------------
package neopixel_pkg;

   localparam int unsigned T0H_NS    = 350;
   localparam int unsigned T1H_NS    = 700;
   localparam int unsigned TH_NS     = 525;
   localparam int unsigned GLITCH_NS = 150;
   localparam int unsigned HMAX_NS   = 2000;
   localparam int unsigned RST_US    = 50;

   // Ticks per microsecond are computed first so that the result matches the
   // integer arithmetic used by the transmit side exactly.
   function automatic int unsigned ns_to_tck(input int unsigned clk_hz,
                                             input int unsigned ns);
      return clk_hz / 1_000_000 * ns / 1000;
   endfunction

   function automatic int unsigned us_to_tck(input int unsigned clk_hz,
                                             input int unsigned us);
      return clk_hz / 1_000_000 * us;
   endfunction

   typedef enum logic [1:0] {
      ARM,
      IDLE,
      HIGH,
      LOW
   } rx_state_t;

endpackage

// File: rtl/neopixel_sync2.sv
// -----------------------------------------------------------------------------
// neopixel_sync2
//
// Two-flop synchroniser for an asynchronous single-bit input, with registered
// one-cycle rise/fall pulses that line up with the synchronised level.
//
// Ports:
//   clk    in   sampling clock
//   rst_n  in   asynchronous active-low reset
//   din    in   asynchronous input
//   level  out  synchronised level (2 flops after din)
//   rise   out  one-cycle pulse on the first cycle level is high
//   fall   out  one-cycle pulse on the first cycle level is low
// -----------------------------------------------------------------------------
module neopixel_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta_q;
   logic sync_q;
   logic rise_q;
   logic fall_q;

   // The edge pulses are computed from the two synchroniser stages and
   // registered on the same edge that updates sync_q, so a pulse is high in
   // exactly the first cycle of the new level and adds no extra latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         meta_q <= din;
         sync_q <= meta_q;
         rise_q <= meta_q & ~sync_q;
         fall_q <= ~meta_q & sync_q;
      end
   end

   assign level = sync_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule

// File: rtl/neopixel_rx.sv
// -----------------------------------------------------------------------------
// neopixel_rx
//
// WS2812 single-wire stream receiver. Each high pulse is measured and
// classified as a 0 or 1 bit; bits are assembled MSB-first into bytes that are
// written into an external LEDS*3-byte frame buffer (G,R,B per LED).
//
// Optional feature macro: NEOPIXEL_RX_ERR_EN
//   When defined, adds o_err (pulse per rejected glitch or over-long high
//   abort) and o_err_cnt (saturating error count, cleared by reset only).
//
// Ports:
//   i_clk          in   system clock
//   i_rst_n        in   asynchronous active-low reset
//   i_din          in   NeoPixel data line (asynchronous)
//   o_wr_en        out  one-cycle buffer write strobe
//   o_wr_addr      out  byte address for o_wr_data
//   o_wr_data      out  received byte
//   o_busy         out  high while a frame is being received
//   o_frame_done   out  one-cycle pulse at end of frame
//   o_frame_bytes  out  complete bytes written in the last frame
//   o_overflow     out  sticky: frame exceeded LEDS*3 bytes
//   o_err          out  (NEOPIXEL_RX_ERR_EN) error pulse
//   o_err_cnt      out  (NEOPIXEL_RX_ERR_EN) saturating error count
// -----------------------------------------------------------------------------
module neopixel_rx
   import neopixel_pkg::*;
#(
   parameter  int LEDS   = 200,
   parameter  int CLK_HZ = 50_000_000,
   localparam int AW     = $clog2(LEDS * 3)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_din,
   output logic          o_wr_en,
   output logic [AW-1:0] o_wr_addr,
   output logic [7:0]    o_wr_data,
   output logic          o_busy,
   output logic          o_frame_done,
   output logic [AW:0]   o_frame_bytes,
   output logic          o_overflow
`ifdef NEOPIXEL_RX_ERR_EN
   ,
   output logic          o_err,
   output logic [7:0]    o_err_cnt
`endif
);

   localparam int unsigned TH_TCK     = ns_to_tck(CLK_HZ, TH_NS);
   localparam int unsigned GLITCH_TCK = ns_to_tck(CLK_HZ, GLITCH_NS);
   localparam int unsigned HMAX_TCK   = ns_to_tck(CLK_HZ, HMAX_NS);
   localparam int unsigned RST_TCK    = us_to_tck(CLK_HZ, RST_US);

   localparam int HW    = $clog2(HMAX_TCK + 1);
   localparam int LW    = $clog2(RST_TCK + 1);
   localparam int DEPTH = LEDS * 3;

   localparam logic [HW-1:0] TH_C       = HW'(TH_TCK);
   localparam logic [HW-1:0] GLITCH_C   = HW'(GLITCH_TCK);
   localparam logic [HW-1:0] HMAX_C     = HW'(HMAX_TCK);
   localparam logic [HW-1:0] HI_ONE     = HW'(1);
   localparam logic [LW-1:0] RST_LAST_C = LW'(RST_TCK - 1);
   localparam logic [LW-1:0] LO_ONE     = LW'(1);
   localparam logic [AW:0]   DEPTH_C    = (AW + 1)'(DEPTH);
   localparam logic [AW:0]   BYTE_ONE   = (AW + 1)'(1);

   logic din_level;
   logic din_rise;
   logic din_fall;

   rx_state_t     state_q,       state_d;
   logic [HW-1:0] hi_cnt_q,      hi_cnt_d;
   logic [LW-1:0] lo_cnt_q,      lo_cnt_d;
   logic [7:0]    shreg_q,       shreg_d;
   logic [2:0]    bit_cnt_q,     bit_cnt_d;
   logic [AW:0]   byte_cnt_q,    byte_cnt_d;
   logic          wr_en_q,       wr_en_d;
   logic [AW-1:0] wr_addr_q,     wr_addr_d;
   logic [7:0]    wr_data_q,     wr_data_d;
   logic          busy_q,        busy_d;
   logic          done_q,        done_d;
   logic [AW:0]   frame_bytes_q, frame_bytes_d;
   logic          ovf_q,         ovf_d;
   logic          bit_v;
   logic [7:0]    byte_v;
`ifdef NEOPIXEL_RX_ERR_EN
   logic          err_q,         err_d;
   logic [7:0]    err_cnt_q,     err_cnt_d;
`endif

   neopixel_sync2 u_sync (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .din   (i_din),
      .level (din_level),
      .rise  (din_rise),
      .fall  (din_fall)
   );

   // All receiver state, counters and outputs are registered here; the
   // next-state values come from the combinational block below.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q       <= ARM;
         hi_cnt_q      <= '0;
         lo_cnt_q      <= '0;
         shreg_q       <= '0;
         bit_cnt_q     <= '0;
         byte_cnt_q    <= '0;
         wr_en_q       <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         frame_bytes_q <= '0;
         ovf_q         <= 1'b0;
`ifdef NEOPIXEL_RX_ERR_EN
         err_q         <= 1'b0;
         err_cnt_q     <= '0;
`endif
      end else begin
         state_q       <= state_d;
         hi_cnt_q      <= hi_cnt_d;
         lo_cnt_q      <= lo_cnt_d;
         shreg_q       <= shreg_d;
         bit_cnt_q     <= bit_cnt_d;
         byte_cnt_q    <= byte_cnt_d;
         wr_en_q       <= wr_en_d;
         wr_addr_q     <= wr_addr_d;
         wr_data_q     <= wr_data_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         frame_bytes_q <= frame_bytes_d;
         ovf_q         <= ovf_d;
`ifdef NEOPIXEL_RX_ERR_EN
         err_q         <= err_d;
         err_cnt_q     <= err_cnt_d;
`endif
      end
   end

   // Next-state logic. The rise pulse loads hi_cnt with 1 and the fall pulse
   // loads lo_cnt with 1, so each counter holds the exact number of cycles
   // the synchronised line has spent at its level when the next decision is
   // taken. The byte counter doubles as the write address and is never
   // advanced past the buffer depth, which makes o_frame_bytes saturate.
   always_comb begin
      state_d       = state_q;
      hi_cnt_d      = hi_cnt_q;
      lo_cnt_d      = lo_cnt_q;
      shreg_d       = shreg_q;
      bit_cnt_d     = bit_cnt_q;
      byte_cnt_d    = byte_cnt_q;
      wr_en_d       = 1'b0;
      wr_addr_d     = wr_addr_q;
      wr_data_d     = wr_data_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      frame_bytes_d = frame_bytes_q;
      ovf_d         = ovf_q;
      bit_v         = (hi_cnt_q >= TH_C);
      byte_v        = {shreg_q[6:0], bit_v};
`ifdef NEOPIXEL_RX_ERR_EN
      err_d         = 1'b0;
`endif

      case (state_q)
         // Wait for a full reset gap so capture never starts mid-frame.
         ARM: begin
            if (din_level) begin
               lo_cnt_d = '0;
            end else if (lo_cnt_q >= RST_LAST_C) begin
               lo_cnt_d = '0;
               state_d  = IDLE;
            end else begin
               lo_cnt_d = lo_cnt_q + LO_ONE;
            end
         end

         IDLE: begin
            if (din_rise) begin
               byte_cnt_d = '0;
               bit_cnt_d  = '0;
               wr_addr_d  = '0;
               ovf_d      = 1'b0;
               busy_d     = 1'b1;
               hi_cnt_d   = HI_ONE;
               state_d    = HIGH;
            end
         end

         HIGH: begin
            if (din_fall) begin
               lo_cnt_d = LO_ONE;
               state_d  = LOW;
               if (hi_cnt_q < GLITCH_C) begin
`ifdef NEOPIXEL_RX_ERR_EN
                  err_d = 1'b1;
`endif
               end else begin
                  shreg_d   = byte_v;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     if (byte_cnt_q < DEPTH_C) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = byte_cnt_q[AW-1:0];
                        wr_data_d  = byte_v;
                        byte_cnt_d = byte_cnt_q + BYTE_ONE;
                     end else begin
                        ovf_d = 1'b1;
                     end
                  end
               end
            end else if (hi_cnt_q >= HMAX_C) begin
               // A stuck-high line is not a valid frame; resynchronise.
               lo_cnt_d = '0;
               busy_d   = 1'b0;
               state_d  = ARM;
`ifdef NEOPIXEL_RX_ERR_EN
               err_d    = 1'b1;
`endif
            end else begin
               hi_cnt_d = hi_cnt_q + HI_ONE;
            end
         end

         LOW: begin
            if (din_rise) begin
               hi_cnt_d = HI_ONE;
               state_d  = HIGH;
            end else if (lo_cnt_q >= RST_LAST_C) begin
               // End of frame; any partial byte in shreg is simply dropped.
               done_d        = 1'b1;
               frame_bytes_d = byte_cnt_q;
               busy_d        = 1'b0;
               lo_cnt_d      = '0;
               state_d       = IDLE;
            end else begin
               lo_cnt_d = lo_cnt_q + LO_ONE;
            end
         end

         default: begin
            state_d = ARM;
         end
      endcase

`ifdef NEOPIXEL_RX_ERR_EN
      err_cnt_d = err_cnt_q;
      if (err_d && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
`endif
   end

   assign o_wr_en       = wr_en_q;
   assign o_wr_addr     = wr_addr_q;
   assign o_wr_data     = wr_data_q;
   assign o_busy        = busy_q;
   assign o_frame_done  = done_q;
   assign o_frame_bytes = frame_bytes_q;
   assign o_overflow    = ovf_q;
`ifdef NEOPIXEL_RX_ERR_EN
   assign o_err         = err_q;
   assign o_err_cnt     = err_cnt_q;
`endif

endmodule
